// File: rtl/rr_arb_wrr_if.sv
// rr_arb_wrr_if: request/weight/done inputs and registered grant outputs of the weighted round-robin arbiter.
interface rr_arb_wrr_if #(
  parameter int N = 4,
  parameter int IDX_W = $clog2(N),
  parameter int WGT_W = 4
) ();
  logic [N-1:0]       rr_req;
  logic [N*WGT_W-1:0] rr_weight;
  logic               gnt_done;
  logic               gnt_valid;
  logic [N-1:0]       gnt_onehot;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_last;
  modport master (output rr_req, rr_weight, gnt_done, input gnt_valid, gnt_onehot, gnt_idx, gnt_last);
  modport slave (input rr_req, rr_weight, gnt_done, output gnt_valid, gnt_onehot, gnt_idx, gnt_last);
endinterface

// File: rtl/rr_arb_wrr.sv
// rr_arb_wrr: N-way weighted round-robin arbiter with registered, held grants released by gnt_done.
module rr_arb_wrr #(
  parameter int N = 4,
  parameter int IDX_W = $clog2(N),
  parameter int WGT_W = 4
) (
  input logic sys_clk,
  input logic sys_rst_n,
  rr_arb_wrr_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t st, st_d;
  logic [IDX_W-1:0] ptr, ptr_d, p, p_d, w;
  logic [WGT_W-1:0] q, q_d, wv, wq;
  logic [N-1:0] oh, oh_d;
  logic last, last_d;
  function automatic logic [IDX_W-1:0] lsb(input logic [N-1:0] v);
    lsb = '0;
    for (int i = N - 1; i >= 0; i--) if (v[i]) lsb = IDX_W'(i);
  endfunction
  // Masked priority: ports above base first, then wrap to the full request vector.
  function automatic logic [IDX_W-1:0] sel(input logic [N-1:0] req, input logic [IDX_W-1:0] base);
    logic [N-1:0] m;
    m = req & ~((N'(2) << base) - N'(1));
    sel = |m ? lsb(m) : lsb(req);
  endfunction
  always_comb begin
    w = sel(bus.rr_req, st == IDLE ? ptr : p);
    wv = bus.rr_weight[int'(w)*WGT_W +: WGT_W];
    wq = wv == '0 ? WGT_W'(1) : wv;
    st_d = st;
    p_d = p;
    q_d = q;
    ptr_d = ptr;
    last_d = last;
    if (st == IDLE) begin
      if (|bus.rr_req) begin
        st_d = GRANT;
        p_d = w;
        ptr_d = w;
        q_d = wq;
        last_d = wq == WGT_W'(1) || !bus.rr_req[w];
      end
    end else if (bus.gnt_done) begin
      if (q > WGT_W'(1) && bus.rr_req[p]) begin
        q_d = q - WGT_W'(1);
        last_d = q_d == WGT_W'(1);
      end else if (|bus.rr_req) begin
        p_d = w;
        ptr_d = w;
        q_d = wq;
        last_d = wq == WGT_W'(1) || !bus.rr_req[w];
      end else begin
        st_d = IDLE;
        p_d = '0;
        q_d = '0;
        last_d = 1'b0;
      end
    end
    oh_d = st_d == GRANT ? N'(1) << p_d : '0;
  end
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      st <= IDLE;
      ptr <= IDX_W'(N - 1);
      p <= '0;
      q <= '0;
      oh <= '0;
      last <= 1'b0;
    end else begin
      st <= st_d;
      ptr <= ptr_d;
      p <= p_d;
      q <= q_d;
      oh <= oh_d;
      last <= last_d;
    end
  end
  assign bus.gnt_valid = st == GRANT;
  assign bus.gnt_onehot = oh;
  assign bus.gnt_idx = p;
  assign bus.gnt_last = last;
endmodule

// File: tb/tb_rr_arb_wrr.sv
// tb_rr_arb_wrr: directed vector table plus hand-written hold/wrap and mid-burst reset sequences for rr_arb_wrr.
module tb_rr_arb_wrr;
  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int errors = 0;
  int checks = 0;
  rr_arb_wrr_if #(.N(4)) bus ();
  rr_arb_wrr dut (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus));
  always #5 sys_clk = ~sys_clk;
  typedef struct {
    logic [3:0]  req;
    logic [15:0] wgt;
    logic        done;
    logic        v;
    logic [1:0]  idx;
    logic        last;
  } vec_t;
  vec_t tbl[22];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic v, input logic [1:0] idx, input logic last);
    logic [3:0] oh;
    oh = v ? 4'b0001 << idx : 4'b0000;
    chk({tag, ".valid"}, 32'(bus.gnt_valid), 32'(v));
    chk({tag, ".idx"}, 32'(bus.gnt_idx), 32'(idx));
    chk({tag, ".last"}, 32'(bus.gnt_last), 32'(last));
    chk({tag, ".onehot"}, 32'(bus.gnt_onehot), 32'(oh));
  endtask
  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask
  task automatic drive(input logic [3:0] req, input logic [15:0] wgt, input logic done);
    bus.rr_req = req;
    bus.rr_weight = wgt;
    bus.gnt_done = done;
  endtask
  initial begin
    logic [3:0] hold_req[5];
    tbl[0]  = '{4'h1, 16'h1111, 1'b0, 1'b1, 2'd0, 1'b1};
    tbl[1]  = '{4'h0, 16'h1111, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[2]  = '{4'hF, 16'h1111, 1'b0, 1'b1, 2'd1, 1'b1};
    tbl[3]  = '{4'hF, 16'h1111, 1'b1, 1'b1, 2'd2, 1'b1};
    tbl[4]  = '{4'hF, 16'h1111, 1'b1, 1'b1, 2'd3, 1'b1};
    tbl[5]  = '{4'hF, 16'h1111, 1'b1, 1'b1, 2'd0, 1'b1};
    tbl[6]  = '{4'hF, 16'h1111, 1'b1, 1'b1, 2'd1, 1'b1};
    tbl[7]  = '{4'hF, 16'h1111, 1'b1, 1'b1, 2'd2, 1'b1};
    tbl[8]  = '{4'h3, 16'h0023, 1'b1, 1'b1, 2'd0, 1'b0};
    tbl[9]  = '{4'h3, 16'h0023, 1'b1, 1'b1, 2'd0, 1'b0};
    tbl[10] = '{4'h3, 16'h0023, 1'b1, 1'b1, 2'd0, 1'b1};
    tbl[11] = '{4'h3, 16'h0023, 1'b1, 1'b1, 2'd1, 1'b0};
    tbl[12] = '{4'h3, 16'h0023, 1'b1, 1'b1, 2'd1, 1'b1};
    tbl[13] = '{4'h3, 16'h0023, 1'b1, 1'b1, 2'd0, 1'b0};
    tbl[14] = '{4'h3, 16'h0023, 1'b1, 1'b1, 2'd0, 1'b0};
    tbl[15] = '{4'h0, 16'h0023, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[16] = '{4'h1, 16'h0004, 1'b0, 1'b1, 2'd0, 1'b0};
    tbl[17] = '{4'h5, 16'h0004, 1'b1, 1'b1, 2'd0, 1'b0};
    tbl[18] = '{4'h4, 16'h0004, 1'b1, 1'b1, 2'd2, 1'b1};
    tbl[19] = '{4'h4, 16'h0004, 1'b0, 1'b1, 2'd2, 1'b1};
    tbl[20] = '{4'h0, 16'h0004, 1'b1, 1'b0, 2'd0, 1'b0};
    tbl[21] = '{4'h0, 16'h0004, 1'b1, 1'b0, 2'd0, 1'b0};
    hold_req = '{4'h1, 4'h6, 4'hF, 4'h0, 4'h9};
    drive(4'h0, 16'h1111, 1'b0);
    step();
    chk_out("reset", 1'b0, 2'd0, 1'b0);
    #3 sys_rst_n = 1'b1;
    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].req, tbl[i].wgt, tbl[i].done);
      step();
      chk_out($sformatf("vec%0d", i), tbl[i].v, tbl[i].idx, tbl[i].last);
    end
    drive(4'h8, 16'h0000, 1'b0);
    step();
    chk_out("grant3", 1'b1, 2'd3, 1'b1);
    for (int i = 0; i < 5; i++) begin
      drive(hold_req[i], 16'h0000, 1'b0);
      step();
      chk_out($sformatf("hold%0d", i), 1'b1, 2'd3, 1'b1);
    end
    drive(4'h9, 16'h0000, 1'b1);
    step();
    chk_out("wrap", 1'b1, 2'd0, 1'b1);
    drive(4'h4, 16'h0300, 1'b1);
    step();
    chk_out("burst2_a", 1'b1, 2'd2, 1'b0);
    step();
    chk_out("burst2_b", 1'b1, 2'd2, 1'b0);
    drive(4'h6, 16'h0000, 1'b0);
    #2 sys_rst_n = 1'b0;
    #1 chk_out("async_rst", 1'b0, 2'd0, 1'b0);
    step();
    chk_out("rst_held", 1'b0, 2'd0, 1'b0);
    #3 sys_rst_n = 1'b1;
    step();
    chk_out("post_rst", 1'b1, 2'd1, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
